// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver. It delivers each received frame on a
// valid/ready port together with framing, parity and overrun status.
module uart_rx_param #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned DATA_BITS    = 8,
   parameter bit          MSB_FIRST    = 1'b1,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0] IdxDataLast = IdxW'(DATA_BITS - 1);
   localparam logic [IdxW-1:0] IdxStopLast = IdxW'(STOP_BITS - 1);
   localparam bit OddParity = (PARITY == 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                 state_q, state_d;
   logic                   sync1_q, sync2_q, prev_q;
   logic                   live1_q, live2_q, armed_q;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   start_edge;
   logic                   frame_done;
   logic                   done_ferr;
   logic [DATA_BITS-1:0]   rx_data_q;
   logic                   rx_valid_q, frame_err_q, parity_err_q, overrun_q;

   // Line synchronizer, edge history and arming. The line only counts as idle once a
   // real high level has made it through the synchronizer, so a line held low across
   // reset release cannot start a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         live1_q <= 1'b0;
         live2_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         live1_q <= 1'b1;
         live2_q <= live1_q;
         if (live2_q && sync2_q) armed_q <= 1'b1;
      end
   end

   assign start_edge = armed_q && prev_q && !sync2_q;

   // FSM and datapath state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic. The cycle counter restarts on every state entry and sampling
   // happens on its last count, mid-bit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      frame_done = 1'b0;
      done_ferr  = ferr_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            if (start_edge) begin
               state_d = StStart;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d   = '0;
               // A high line at mid start bit is a glitch: drop it silently.
               state_d = sync2_q ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == CntFull) begin
               cnt_d = '0;
               if (MSB_FIRST) shreg_d = {shreg_q[DATA_BITS-2:0], sync2_q};
               else           shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
               if (idx_q == IdxDataLast) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (cnt_q == CntFull) begin
               cnt_d   = '0;
               perr_d  = ((^shreg_q) ^ sync2_q) != OddParity;
               state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == CntFull) begin
               cnt_d = '0;
               if (!sync2_q) ferr_d = 1'b1;
               done_ferr = ferr_q | ~sync2_q;
               if (idx_q == IdxStopLast) begin
                  // Leave mid stop bit so a start edge half a bit later is caught.
                  idx_d      = '0;
                  frame_done = 1'b1;
                  state_d    = StIdle;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output holding register and handshake; a frame completing while the previous one
   // is still unaccepted is dropped and flagged with a one-cycle overrun pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
               rx_data_q    <= shreg_q;
               rx_valid_q   <= 1'b1;
               frame_err_q  <= done_ferr;
               parity_err_q <= perr_q;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (default, LSB-first, even parity),
// a frame-level model of expected deliveries, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       line  [3];
   logic       ready [3];
   logic [7:0] data  [3];
   logic       valid [3];
   logic       ferr  [3];
   logic       perr  [3];
   logic       ovr   [3];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .MSB_FIRST(1'b1), .PARITY(0),
                   .STOP_BITS(1)) u_def (
      .clk(clk), .reset_n(reset_n), .uart_rx(line[0]), .rx_data(data[0]),
      .rx_valid(valid[0]), .rx_ready(ready[0]), .frame_err(ferr[0]),
      .parity_err(perr[0]), .overrun(ovr[0]));

   uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .MSB_FIRST(1'b0), .PARITY(0),
                   .STOP_BITS(1)) u_lsb (
      .clk(clk), .reset_n(reset_n), .uart_rx(line[1]), .rx_data(data[1]),
      .rx_valid(valid[1]), .rx_ready(ready[1]), .frame_err(ferr[1]),
      .parity_err(perr[1]), .overrun(ovr[1]));

   uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .MSB_FIRST(1'b1), .PARITY(2),
                   .STOP_BITS(1)) u_par (
      .clk(clk), .reset_n(reset_n), .uart_rx(line[2]), .rx_data(data[2]),
      .rx_valid(valid[2]), .rx_ready(ready[2]), .frame_err(ferr[2]),
      .parity_err(perr[2]), .overrun(ovr[2]));

   function automatic bit dut_msb(input int k);
      return k != 1;
   endfunction

   function automatic int dut_npar(input int k);
      return (k == 2) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected deliveries: which DUT, the cycle rx_valid should rise, payload and flags.
   typedef struct {
      int         k;
      int         v;
      logic [7:0] d;
      bit         f;
      bit         p;
   } rec_t;
   rec_t pend[$];

   bit         mv [3];
   bit         mf [3];
   bit         mp [3];
   bit         mo [3];
   logic [7:0] md [3];
   int         ovr_cnt [3];
   int         ovr_cyc [3];

   // Model: applied at each rising edge, using rx_ready as it was in the ending cycle.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (!reset_n) begin
            pend.delete();
            for (int k = 0; k < 3; k++) begin
               mv[k] = 0; mf[k] = 0; mp[k] = 0; mo[k] = 0; md[k] = '0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               int hit;
               hit = -1;
               for (int i = 0; i < pend.size(); i++)
                  if (pend[i].k == k && pend[i].v == cyc) hit = i;
               mo[k] = 0;
               if (hit >= 0) begin
                  if (!mv[k] || ready[k]) begin
                     mv[k] = 1; md[k] = pend[hit].d; mf[k] = pend[hit].f; mp[k] = pend[hit].p;
                  end else begin
                     mo[k] = 1;
                  end
                  pend.delete(hit);
               end else if (mv[k] && ready[k]) begin
                  mv[k] = 0;
               end
            end
         end
      end
   end

   // Compare process: every falling edge out of reset, each DUT against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("cmp%0d_valid", k), 32'(valid[k]), 32'(mv[k]));
               chk($sformatf("cmp%0d_overrun", k), 32'(ovr[k]), 32'(mo[k]));
               if (ovr[k] === 1'b1) begin
                  ovr_cnt[k]++;
                  ovr_cyc[k] = cyc;
               end
               if (mv[k]) begin
                  chk($sformatf("cmp%0d_data", k), 32'(data[k]), 32'(md[k]));
                  chk($sformatf("cmp%0d_frame_err", k), 32'(ferr[k]), 32'(mf[k]));
                  chk($sformatf("cmp%0d_parity_err", k), 32'(perr[k]), 32'(mp[k]));
               end
            end
         end
      end
   end

   // Drive one frame on DUT k's line. lb[7] is the first data bit on the line.
   // Start is driven in cycle n; the synchronizer sees it at T = n + 2.
   task automatic send_frame(input int k, input logic [7:0] lb, input logic par_bit,
                             input logic stop, output int n);
      rec_t       r;
      logic [7:0] d;
      int         ones;
      @(posedge clk); #1;
      n    = cyc;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         if (dut_msb(k)) d[7-i] = lb[7-i];
         else            d[i]   = lb[7-i];
         ones += int'(lb[i]);
      end
      r.k = k;
      r.v = n + 2 + CPB / 2 + (8 + dut_npar(k) + 1) * CPB + 1;
      r.d = d;
      r.f = (stop == 1'b0);
      r.p = (dut_npar(k) == 1) && (((ones + int'(par_bit)) % 2) != 0);
      pend.push_back(r);
      line[k] = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 7; i >= 0; i--) begin
         line[k] = lb[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      if (dut_npar(k) == 1) begin
         line[k] = par_bit;
         repeat (CPB) @(posedge clk);
         #1;
      end
      line[k] = stop;
      repeat (CPB) @(posedge clk);
      #1;
      line[k] = 1'b1;
   endtask

   // Wait (bounded) for rx_valid and capture what was presented in that cycle.
   task automatic wait_valid(input int k, output int c, output logic [7:0] d,
                             output logic f, output logic p);
      c = -1; d = '0; f = 0; p = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (valid[k] === 1'b1) begin
            c = cyc; d = data[k]; f = ferr[k]; p = perr[k];
            break;
         end
      end
      if (c < 0) chk($sformatf("timeout_dut%0d", k), 32'(0), 32'(1));
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Send, wait for delivery, and pin the latency and contents with literal values.
   task automatic frame_check(input string name, input int k, input logic [7:0] lb,
                              input logic par_bit, input logic stop, input int lat,
                              input logic [7:0] exp_d, input logic exp_f, input logic exp_p);
      int n, c;
      logic [7:0] d;
      logic f, p;
      fork
         send_frame(k, lb, par_bit, stop, n);
         wait_valid(k, c, d, f, p);
      join
      chk({name, "_latency"}, 32'(c - n), 32'(lat));
      chk({name, "_data"}, 32'(d), 32'(exp_d));
      chk({name, "_frame_err"}, 32'(f), 32'(exp_f));
      chk({name, "_parity_err"}, 32'(p), 32'(exp_p));
      @(negedge clk);
      chk({name, "_one_cycle"}, 32'(valid[k]), 32'(0));
      idle(6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n1, n2, base;
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         line[k]    = 1'b1;
         ready[k]   = 1'b1;
         ovr_cnt[k] = 0;
         ovr_cyc[k] = 0;
      end
      idle(3);
      chk("reset_valid", 32'(valid[0]), 32'(0));
      chk("reset_data", 32'(data[0]), 32'(0));
      chk("reset_flags", 32'({ferr[0], perr[0], ovr[0]}), 32'(0));
      reset_n = 1'b1;
      idle(6);

      // Default config: 0xA5, visible at T+77 = n+79.
      frame_check("t1", 0, 8'hA5, 1'b0, 1'b1, 79, 8'hA5, 1'b0, 1'b0);

      // LSB-first: palindrome, then line order 1,0,0,0,0,0,0,0 gives 0x01.
      frame_check("t2a", 1, 8'hA5, 1'b0, 1'b1, 79, 8'hA5, 1'b0, 1'b0);
      frame_check("t2b", 1, 8'h80, 1'b0, 1'b1, 79, 8'h01, 1'b0, 1'b0);

      // Even parity: 0xA5 has four ones, so parity bit 0 is good, 1 is bad.
      frame_check("t3a", 2, 8'hA5, 1'b0, 1'b1, 87, 8'hA5, 1'b0, 1'b0);
      frame_check("t3b", 2, 8'hA5, 1'b1, 1'b1, 87, 8'hA5, 1'b0, 1'b1);

      // Low stop bit, then a clean frame.
      frame_check("t4a", 0, 8'h3C, 1'b0, 1'b0, 79, 8'h3C, 1'b1, 1'b0);
      idle(4);
      frame_check("t4b", 0, 8'h11, 1'b0, 1'b1, 79, 8'h11, 1'b0, 1'b0);

      // Two-cycle glitch: nothing delivered; a real frame 20 cycles later is.
      line[0] = 1'b0;
      idle(2);
      line[0] = 1'b1;
      idle(20);
      chk("t5_glitch_no_valid", 32'(valid[0]), 32'(0));
      frame_check("t5", 0, 8'h5A, 1'b0, 1'b1, 79, 8'h5A, 1'b0, 1'b0);

      // Consumer stalled: second frame overruns, first one is kept.
      ready[0] = 1'b0;
      base = ovr_cnt[0];
      send_frame(0, 8'h12, 1'b0, 1'b1, n1);
      send_frame(0, 8'h34, 1'b0, 1'b1, n2);
      idle(3);
      chk("t6_overrun_count", 32'(ovr_cnt[0] - base), 32'(1));
      chk("t6_overrun_cycle", 32'(ovr_cyc[0] - n2), 32'(79));
      chk("t6_held_valid", 32'(valid[0]), 32'(1));
      chk("t6_held_data", 32'(data[0]), 32'(8'h12));

      // Reset in the middle of a frame, with the line held low across release.
      line[0] = 1'b0;
      idle(20);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(valid[0]), 32'(0));
      chk("t6_rst_data", 32'(data[0]), 32'(0));
      chk("t6_rst_flags", 32'({ferr[0], perr[0], ovr[0]}), 32'(0));
      idle(3);
      reset_n = 1'b1;
      idle(30);
      chk("t6_low_line_no_frame", 32'(valid[0]), 32'(0));
      line[0]  = 1'b1;
      ready[0] = 1'b1;
      idle(10);
      frame_check("t6c", 0, 8'h56, 1'b0, 1'b1, 79, 8'h56, 1'b0, 1'b0);

      idle(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
